rmap_wb_arbiter: RTL

RMAP_WB_ARBITER -- requirements
Module: rmap_wb_arbiter

---
 rtl/rmap_wb_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rmap_wb_arbiter.sv
// rmap_wb_arbiter
// Two-master Wishbone arbiter that shares one slave between the RMAP target (master 0)
// and the local host (master 1). Contention is resolved round-robin on the last owner,
// ownership lasts until the owner drops cyc, and a watchdog synthesizes an error when a
// strobe stays unanswered for too long.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   m0*In / m0*Out                 master 0 Wishbone (cyc, stb, we, adr, sel, dat / dat, ack, err)
//   m1*In / m1*Out                 master 1 Wishbone, same set
//   cycOut..datOut, datIn, ackIn,  shared slave Wishbone
//   errIn
//   grant                          one-hot owner (bit0 = m0, bit1 = m1), 00 when idle
//   timeoutError                   one-cycle pulse when the watchdog fires
module rmap_wb_arbiter #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  // master 0
  input  logic                   m0CycIn,
  input  logic                   m0StbIn,
  input  logic                   m0WeIn,
  input  logic [31:0]            m0AdrIn,
  input  logic [BUS_WIDTH/8-1:0] m0SelIn,
  input  logic [BUS_WIDTH-1:0]   m0DatIn,
  output logic [BUS_WIDTH-1:0]   m0DatOut,
  output logic                   m0AckOut,
  output logic                   m0ErrOut,
  // master 1
  input  logic                   m1CycIn,
  input  logic                   m1StbIn,
  input  logic                   m1WeIn,
  input  logic [31:0]            m1AdrIn,
  input  logic [BUS_WIDTH/8-1:0] m1SelIn,
  input  logic [BUS_WIDTH-1:0]   m1DatIn,
  output logic [BUS_WIDTH-1:0]   m1DatOut,
  output logic                   m1AckOut,
  output logic                   m1ErrOut,
  // slave
  output logic                   cycOut,
  output logic                   stbOut,
  output logic                   weOut,
  output logic [31:0]            adrOut,
  output logic [BUS_WIDTH/8-1:0] selOut,
  output logic [BUS_WIDTH-1:0]   datOut,
  input  logic [BUS_WIDTH-1:0]   datIn,
  input  logic                   ackIn,
  input  logic                   errIn,
  // status
  output logic [1:0]             grant,
  output logic                   timeoutError
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} stateT;

  stateT       stateQ, stateD;
  logic        lastOwnerQ, lastOwnerD;  // 1 = master 1 owned the bus last
  logic [15:0] wdCntQ, wdCntD;
  logic        wdFireQ, wdFireD;        // high in the cycle the synthesized error is driven

  logic        ackEff, errEff;
  logic        stalled, ownerHolds;

  // ---------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------
  always_comb begin
    stateD     = stateQ;
    lastOwnerD = lastOwnerQ;
    unique case (stateQ)
      StIdle: begin
        if (m0CycIn && m1CycIn) begin
          stateD = lastOwnerQ ? StOwn0 : StOwn1;
        end else if (m0CycIn) begin
          stateD = StOwn0;
        end else if (m1CycIn) begin
          stateD = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0CycIn) begin
          stateD     = StIdle;
          lastOwnerD = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1CycIn) begin
          stateD     = StIdle;
          lastOwnerD = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= StIdle;
      lastOwnerQ <= 1'b1;
      wdCntQ     <= '0;
      wdFireQ    <= 1'b0;
    end else begin
      stateQ     <= stateD;
      lastOwnerQ <= lastOwnerD;
      wdCntQ     <= wdCntD;
      wdFireQ    <= wdFireD;
    end
  end

  assign grant = {stateQ == StOwn1, stateQ == StOwn0};

  // ---------------------------------------------------------------------------------------
  // Bus routing
  // ---------------------------------------------------------------------------------------
  // During the watchdog cycle the real slave response is discarded and an error is forced.
  assign ackEff = ackIn & ~errIn & ~wdFireQ;
  assign errEff = errIn | wdFireQ;

  always_comb begin
    cycOut   = 1'b0;
    stbOut   = 1'b0;
    weOut    = 1'b0;
    adrOut   = '0;
    selOut   = '0;
    datOut   = '0;
    m0DatOut = '0;
    m0AckOut = 1'b0;
    m0ErrOut = 1'b0;
    m1DatOut = '0;
    m1AckOut = 1'b0;
    m1ErrOut = 1'b0;
    unique case (stateQ)
      StOwn0: begin
        cycOut   = m0CycIn;
        stbOut   = m0StbIn & ~wdFireQ;
        weOut    = m0WeIn;
        adrOut   = m0AdrIn;
        selOut   = m0SelIn;
        datOut   = m0DatIn;
        m0DatOut = datIn;
        m0AckOut = ackEff;
        m0ErrOut = errEff;
      end
      StOwn1: begin
        cycOut   = m1CycIn;
        stbOut   = m1StbIn & ~wdFireQ;
        weOut    = m1WeIn;
        adrOut   = m1AdrIn;
        selOut   = m1SelIn;
        datOut   = m1DatIn;
        m1DatOut = datIn;
        m1AckOut = ackEff;
        m1ErrOut = errEff;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------------------
  // stbOut is already zero in idle and in the fire cycle, so both clear the counter here.
  assign stalled    = stbOut & ~ackIn & ~errIn;
  assign ownerHolds = ((stateQ == StOwn0) && m0CycIn) || ((stateQ == StOwn1) && m1CycIn);

  always_comb begin
    // Fire only if the owner keeps the bus, so the error lands on the same master.
    wdFireD = stalled && ownerHolds && (wdCntQ == TimeoutVal);
    if (!stalled || wdFireD) begin
      wdCntD = '0;
    end else begin
      wdCntD = wdCntQ + 16'd1;
    end
  end

  assign timeoutError = wdFireQ;

endmodule
